cdb_arbiter: RTL and testbench

- Arbitrates the single Common Data Bus between the four result producers: add/sub ALU, multiply ALU, divide ALU and load queue.
- Index order matches the ResStationEN bit order: 0 = add/sub, 1 = mult, 2 = div, 3 = load/store queue.
- The winning producer's tag and result are registered and broadcast for one cycle to the reservation stations and the register-status table.
- Round-robin policy, so no functional unit can starve.

---
 rtl/cdb_arbiter.sv | 178 +++++++++++++++++
 tb/tb_cdb_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin Common Data Bus arbiter for four result producers (add/sub, mult, div, load queue).
// Optional per-unit broadcast counters are enabled with `define CDB_BCAST_CNT_EN.

module cdb_arbiter_chk #(
  parameter int N_REQ = 4
) (
  input logic             clk,
  input logic             rst_n,
  input logic             cdb_hold,
  input logic [N_REQ-1:0] req,
  input logic [N_REQ-1:0] gnt
);

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_hold_no_gnt : assert property (@(posedge clk) disable iff (!rst_n) cdb_hold |-> (gnt == '0));
  a_gnt_has_req : assert property (@(posedge clk) disable iff (!rst_n) ((gnt & ~req) == '0));

endmodule

module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic                    cdb_hold,
  output logic [N_REQ-1:0]        gnt,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic                    tag_err
`ifdef CDB_BCAST_CNT_EN
  ,
  output logic [N_REQ*16-1:0]     bcast_cnt
`endif
);

  // N_REQ is a power of two, so the pointer wraps modulo N_REQ by plain overflow.
  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]  rr_ptr_q;
  logic [PTR_W-1:0]  rr_ptr_d;
  logic [PTR_W-1:0]  cand_s;
  logic [PTR_W-1:0]  win_idx_s;
  logic              win_vld_s;
  logic [TAG_W-1:0]  win_tag_s;
  logic [DATA_W-1:0] win_data_s;
  logic [N_REQ-1:0]  gnt_s;

  logic              cdb_valid_q;
  logic              cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [TAG_W-1:0]  cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q;
  logic [DATA_W-1:0] cdb_data_d;
  logic              tag_err_q;
  logic              tag_err_d;

  // Winner search: first requester at or after rr_ptr, suppressed by hold and reset.
  always_comb begin
    gnt_s     = '0;
    win_vld_s = 1'b0;
    win_idx_s = '0;
    cand_s    = '0;
    if (rst_n && !cdb_hold) begin
      for (int o = 0; o < N_REQ; o++) begin
        cand_s = rr_ptr_q + PTR_W'(o);
        if (!win_vld_s && req[cand_s]) begin
          win_vld_s = 1'b1;
          win_idx_s = cand_s;
        end else begin
          win_vld_s = win_vld_s;
        end
      end
    end else begin
      win_vld_s = 1'b0;
    end
    gnt_s[win_idx_s] = win_vld_s;
  end

  assign win_tag_s  = req_tag[win_idx_s*TAG_W +: TAG_W];
  assign win_data_s = req_data[win_idx_s*DATA_W +: DATA_W];
  assign gnt        = gnt_s;

  // Next broadcast state; a tag-0 grant releases the unit but only raises tag_err.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    tag_err_d   = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    if (win_vld_s) begin
      rr_ptr_d = win_idx_s + PTR_W'(1);
      if (win_tag_s != {TAG_W{1'b0}}) begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = win_tag_s;
        cdb_data_d  = win_data_s;
      end else begin
        tag_err_d = 1'b1;
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Broadcast and pointer registers; reset discards any pending broadcast.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      tag_err_q   <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      tag_err_q   <= tag_err_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign tag_err   = tag_err_q;

`ifdef CDB_BCAST_CNT_EN
  logic [15:0] cnt_q [N_REQ];
  logic [15:0] cnt_d [N_REQ];

  // Saturating per-unit count of grants that produced a real broadcast.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (gnt_s[i] && (win_tag_s != {TAG_W{1'b0}}) && (cnt_q[i] != 16'hFFFF)) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    bcast_cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bcast_cnt[i*16 +: 16] = cnt_q[i];
    end
  end
`endif

  cdb_arbiter_chk #(.N_REQ(N_REQ)) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .cdb_hold (cdb_hold),
    .req      (req),
    .gnt      (gnt_s)
  );

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized self-checking bench for cdb_arbiter against a behavioural round-robin model.
module tb_cdb_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req_r = 4'b0000;
  logic [3:0]    tag_r [N];
  logic [31:0]   data_r [N];
  logic          hold_r = 1'b0;
  logic [15:0]   req_tag_s;
  logic [127:0]  req_data_s;
  logic [3:0]    gnt;
  logic          cdb_valid;
  logic [3:0]    cdb_tag;
  logic [31:0]   cdb_data;
  logic          tag_err;
`ifdef CDB_BCAST_CNT_EN
  logic [63:0]   bcast_cnt;
`endif

  int n_chk = 0;
  int n_pass = 0;

  // behavioural model state
  int          m_ptr;
  logic        m_valid;
  logic [3:0]  m_tag;
  logic [31:0] m_data;
  logic        m_err;
  int          m_cnt [N];
  int          wait_c [N];
  int          win;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_tag_s[i*4 +: 4]    = tag_r[i];
      req_data_s[i*32 +: 32] = data_r[i];
    end
  end

  cdb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_r),
    .req_tag   (req_tag_s),
    .req_data  (req_data_s),
    .cdb_hold  (hold_r),
    .gnt       (gnt),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .tag_err   (tag_err)
`ifdef CDB_BCAST_CNT_EN
    ,
    .bcast_cnt (bcast_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_tag = 4'd0; m_data = 32'd0; m_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; wait_c[i] = 0;
    end
  endtask

  task automatic check_outputs();
    check("cdb_valid", {63'd0, cdb_valid}, {63'd0, m_valid});
    check("cdb_tag", {60'd0, cdb_tag}, {60'd0, m_tag});
    check("cdb_data", {32'd0, cdb_data}, {32'd0, m_data});
    check("tag_err", {63'd0, tag_err}, {63'd0, m_err});
`ifdef CDB_BCAST_CNT_EN
    for (int i = 0; i < N; i++)
      check("bcast_cnt", {48'd0, bcast_cnt[i*16 +: 16]}, 64'(m_cnt[i]));
`endif
  endtask

  // Called at posedge+1 with inputs already set; returns the model's winner (-1 = none).
  task automatic step(output int w);
    logic [3:0] exp_g;
    #1;
    w = -1;
    if (!hold_r)
      for (int o = 0; o < N; o++)
        if (w < 0 && req_r[(m_ptr + o) % N]) w = (m_ptr + o) % N;
    exp_g = (w >= 0) ? (4'b0001 << w) : 4'b0000;
    check("gnt", {60'd0, gnt}, {60'd0, exp_g});
    for (int i = 0; i < N; i++) begin
      if (!req_r[i]) wait_c[i] = 0;
      else if (!hold_r) begin
        if (gnt[i]) begin
          check("fairness", {63'd0, wait_c[i] < N}, 64'd1);
          wait_c[i] = 0;
        end else wait_c[i]++;
      end
    end
    @(posedge clk);
    m_err = 1'b0; m_valid = 1'b0;
    if (w >= 0) begin
      m_ptr = (w + 1) % N;
      if (tag_r[w] != 4'd0) begin
        m_valid = 1'b1; m_tag = tag_r[w]; m_data = data_r[w];
        if (m_cnt[w] < 65535) m_cnt[w]++;
      end else m_err = 1'b1;
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_gnt", {60'd0, gnt}, 64'd0);
    check_outputs();
    repeat (2) @(posedge clk);
    req_r = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      tag_r[i] = 4'(i + 1); data_r[i] = 32'hA0 + 32'(i);
    end
    model_reset();
    req_r = 4'b1111;
    #2;
    do_reset();

    // all four requesting continuously: service 0,1,2,3,0,...
    req_r = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step(win);
      check("rr_order", 64'(win), 64'(k % N));
    end

    // last grant to unit 1, then 1011 -> 3, 0, 1
    req_r = 4'b0010;
    step(win);
    req_r = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      step(win);
      if (win >= 0) req_r[win] = 1'b0;
    end

    // broadcast from unit 2 still appears during hold; unit 0 waits for hold to fall
    req_r = 4'b0100;
    step(win);
    req_r = 4'b0001; hold_r = 1'b1;
    step(win);
    hold_r = 1'b0;
    step(win);
    req_r = 4'b0000;
    step(win);

    // tag 0 from unit 1: error pulse, bus tag/data untouched
    req_r = 4'b0010; tag_r[1] = 4'd0; data_r[1] = 32'h55;
    step(win);
    req_r = 4'b0000; tag_r[1] = 4'd2;
    step(win);

    // grant unit 3, then reset in the middle of the broadcast cycle
    req_r = 4'b1000;
    step(win);
    req_r = 4'b1100;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {63'd0, cdb_valid}, 64'd0);
    do_reset();
    req_r = 4'b1100;
    step(win);
    check("post_rst_first", 64'(win), 64'd2);

    // randomized traffic: units hold requests until granted
    req_r = 4'b0000;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if (i == win) begin
          if ($urandom_range(0, 1) == 0) req_r[i] = 1'b0;
          else begin
            tag_r[i] = 4'($urandom_range(0, 15)); data_r[i] = $urandom;
          end
        end else if (!req_r[i] && $urandom_range(0, 2) == 0) begin
          req_r[i] = 1'b1; tag_r[i] = 4'($urandom_range(0, 15)); data_r[i] = $urandom;
        end
      end
      hold_r = ($urandom_range(0, 4) == 0);
      step(win);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
